dsm_stereo_decimator: RTL and testbench

- Stereo 1-bit delta-sigma demodulator. It turns two pulse-density bitstreams (left/right) back into unsigned DSM_WIDTH-bit PCM samples.
- Filter is a 2nd-order CIC (sinc²) decimator, ratio R = 2^DECIM_LOG2, one shared rate counter for both channels.
- Sits on the receive/loopback side of the stereo DSM path. It is the inverse of the first-order stereo modulator: density P/2^DSM_WIDTH maps back to PCM value P.

---
 rtl/dsm_stereo_decimator.sv | 83 ++++++++
 tb/tb_dsm_stereo_decimator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dsm_stereo_decimator.sv
// Stereo 1-bit delta-sigma demodulator: per-channel 2nd-order CIC (sinc^2)
// decimator by R = 2^DECIM_LOG2, with a shared rate counter and warm-up gating.
module dsm_stereo_decimator #(
  parameter int DSM_WIDTH  = 12,
  parameter int DECIM_LOG2 = 6
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 bit_en,
  input  logic                 left_in,
  input  logic                 right_in,
  output logic [DSM_WIDTH-1:0] left_pcm,
  output logic [DSM_WIDTH-1:0] right_pcm,
  output logic                 pcm_valid
);

  localparam int G     = 2*DECIM_LOG2 + 1;
  localparam int SHIFT = 2*DECIM_LOG2 - DSM_WIDTH;

  if (SHIFT < 0) begin : g_param_check
    $error("dsm_stereo_decimator: 2*DECIM_LOG2 must be >= DSM_WIDTH");
  end

  logic [1:0]            din;
  logic [DECIM_LOG2-1:0] rate_cnt;
  logic [1:0]            warm_cnt;
  logic                  tick;

  assign din  = {right_in, left_in};
  assign tick = bit_en && (rate_cnt == '1);

  // G >= DSM_WIDTH+1 always holds, so any bit above the PCM field means overrange.
  function automatic logic [DSM_WIDTH-1:0] scale_sat(input logic [G-1:0] y);
    logic [G-1:0] s;
    s = y >> SHIFT;
    if (|s[G-1:DSM_WIDTH]) return '1;
    return s[DSM_WIDTH-1:0];
  endfunction

  for (genvar ch = 0; ch < 2; ch++) begin : g_ch
    logic [G-1:0]         i1, i2, d1, d2;
    logic [G-1:0]         c1, c2;
    logic [DSM_WIDTH-1:0] pcm_q;

    // Comb section evaluated from pre-edge state; all arithmetic wraps mod 2^G.
    assign c1 = i2 - d1;
    assign c2 = c1 - d2;

    always_ff @(posedge clk or posedge aclr) begin
      if (aclr) begin
        i1    <= '0;
        i2    <= '0;
        d1    <= '0;
        d2    <= '0;
        pcm_q <= '0;
      end else if (bit_en) begin
        i1 <= i1 + G'(din[ch]);
        i2 <= i2 + i1;
        if (tick) begin
          d1    <= i2;
          d2    <= c1;
          pcm_q <= scale_sat(c2);
        end
      end
    end
  end

  assign left_pcm  = g_ch[0].pcm_q;
  assign right_pcm = g_ch[1].pcm_q;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rate_cnt  <= '0;
      warm_cnt  <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= tick && (warm_cnt == 2'd3);
      if (bit_en) rate_cnt <= rate_cnt + 1'b1;
      if (tick && (warm_cnt != 2'd3)) warm_cnt <= warm_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_dsm_stereo_decimator.sv
// Self-checking bench for dsm_stereo_decimator: table-driven scenarios plus
// reset and step sequences, all checked against a sinc^2 window model.
module tb_dsm_stereo_decimator;

  localparam int W  = 12;
  localparam int DL = 6;
  localparam int R  = 1 << DL;

  logic         clk = 1'b0;
  logic         aclr;
  logic         bit_en;
  logic         left_in;
  logic         right_in;
  logic [W-1:0] left_pcm;
  logic [W-1:0] right_pcm;
  logic         pcm_valid;

  dsm_stereo_decimator #(.DSM_WIDTH(W), .DECIM_LOG2(DL)) dut (
    .clk       (clk),
    .aclr      (aclr),
    .bit_en    (bit_en),
    .left_in   (left_in),
    .right_in  (right_in),
    .left_pcm  (left_pcm),
    .right_pcm (right_pcm),
    .pcm_valid (pcm_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: enabled-bit history and expected outputs.
  bit hist_l [256];
  bit hist_r [256];
  int n_en  = 0;
  int exp_l = 0;
  int exp_r = 0;
  bit exp_v = 1'b0;

  typedef struct {
    int pat_l;
    int pat_r;
    int val_l;
    int val_r;
    int en_mode;
    int cycles;
    int exp_l;
    int exp_r;
    int tol;
    int spacing;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, want);
    end
  endtask

  task automatic chk_tol(input string name, input int act, input int want, input int tol);
    int diff;
    total++;
    diff = (act > want) ? act - want : want - act;
    if (diff > tol) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d +/- %0d", name, cyc, act, want, tol);
    end
  endtask

  // Output of tick k = input convolved with a triangular sinc^2 kernel ending at k*R-2.
  function automatic int sinc2(input int k, input bit right);
    int     nk;
    longint acc;
    nk  = k*R - 2;
    acc = 0;
    for (int j = nk - 2*R + 1; j < nk; j++) begin
      if (j >= 0) begin
        int t;
        int w;
        t = nk - j;
        w = (t <= R) ? t : 2*R - t;
        acc += w * int'(right ? hist_r[8'(j)] : hist_l[8'(j)]);
      end
    end
    acc = acc % (longint'(1) << (2*DL + 1));
    acc = acc >> (2*DL - W);
    return (acc >= (longint'(1) << W)) ? (1 << W) - 1 : int'(acc);
  endfunction

  task automatic model_edge(input bit en, input bit l, input bit r);
    exp_v = 1'b0;
    if (en) begin
      hist_l[8'(n_en)] = l;
      hist_r[8'(n_en)] = r;
      if (n_en % R == R - 1) begin
        int k;
        k     = (n_en + 1) / R;
        exp_l = sinc2(k, 1'b0);
        exp_r = sinc2(k, 1'b1);
        exp_v = (k >= 4);
      end
      n_en++;
    end
  endtask

  task automatic cycle(input bit en, input bit l, input bit r);
    bit_en   = en;
    left_in  = l;
    right_in = r;
    @(posedge clk);
    model_edge(en, l, r);
    @(negedge clk);
    cyc++;
    chk("pcm_valid", int'(pcm_valid), int'(exp_v));
    chk("left_pcm", int'(left_pcm), exp_l);
    chk("right_pcm", int'(right_pcm), exp_r);
  endtask

  task automatic do_reset();
    aclr     = 1'b1;
    bit_en   = 1'b0;
    left_in  = 1'b0;
    right_in = 1'b0;
    #1;
    chk("rst_valid", int'(pcm_valid), 0);
    chk("rst_left", int'(left_pcm), 0);
    chk("rst_right", int'(right_pcm), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    aclr  = 1'b0;
    n_en  = 0;
    exp_l = 0;
    exp_r = 0;
    exp_v = 1'b0;
  endtask

  // 0 zeros, 1 ones, 2 alternating from 1, 3 alternating from 0, 4 first-order DSM, 5 random.
  function automatic bit gen_bit(input int pat, input int val, input int idx, inout int acc);
    case (pat)
      0: return 1'b0;
      1: return 1'b1;
      2: return idx[0] == 1'b0;
      3: return idx[0] == 1'b1;
      4: begin
        acc += val;
        if (acc >= (1 << W)) begin
          acc -= (1 << W);
          return 1'b1;
        end
        return 1'b0;
      end
      default: return 1'($urandom_range(1));
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int accl;
    int accr;
    int idx;
    int last;
    int nv;
    bit en;
    bit l;
    bit r;
    accl = 0;
    accr = 0;
    idx  = 0;
    last = -1;
    nv   = 0;
    do_reset();
    for (int c = 0; c < v.cycles; c++) begin
      case (v.en_mode)
        0:       en = 1'b1;
        1:       en = (c % 2 == 0);
        default: en = ($urandom_range(3) != 0);
      endcase
      if (en) begin
        l = gen_bit(v.pat_l, v.val_l, idx, accl);
        r = gen_bit(v.pat_r, v.val_r, idx, accr);
        idx++;
      end else begin
        l = 1'($urandom_range(1));
        r = 1'($urandom_range(1));
      end
      cycle(en, l, r);
      if (pcm_valid) begin
        nv++;
        if (v.tol >= 0) begin
          chk_tol($sformatf("vec%0d_left_level", id), int'(left_pcm), v.exp_l, v.tol);
          chk_tol($sformatf("vec%0d_right_level", id), int'(right_pcm), v.exp_r, v.tol);
        end
        if (v.spacing > 0 && last >= 0)
          chk($sformatf("vec%0d_spacing", id), cyc - last, v.spacing);
        last = cyc;
      end
    end
    if (v.en_mode < 2)
      chk($sformatf("vec%0d_valid_count", id), nv, v.cycles / (R * (v.en_mode + 1)) - 3);
  endtask

  initial begin
    int  nbits;
    bit  found;
    int  nv;
    int  first_full;

    vecs[0] = '{1, 0, 0, 0, 0, 768, 4095, 0, 0, 64};
    vecs[1] = '{2, 3, 0, 0, 0, 768, 2048, 2048, 0, 64};
    vecs[2] = '{1, 1, 0, 0, 1, 1536, 4095, 4095, 0, 128};
    vecs[3] = '{4, 4, 1000, 3500, 0, 20000, 1000, 3500, 64, 64};
    vecs[4] = '{5, 4, 0, int'($urandom_range(4095)), 2, 4000, 0, 0, -1, 0};

    do_reset();
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

    // Reset mid-window, then time the first strobe of a fresh count.
    do_reset();
    for (int c = 0; c < 4*R + 30; c++) cycle(1'b1, 1'b1, 1'b0);
    do_reset();
    nbits = 0;
    found = 1'b0;
    for (int c = 0; c < 400 && !found; c++) begin
      cycle(1'b1, 1'b1, 1'b1);
      nbits++;
      if (pcm_valid) found = 1'b1;
    end
    chk("first_valid_seen", int'(found), 1);
    chk("first_valid_bits", nbits, 4*R);
    // Reset lands while the strobe is high.
    do_reset();

    // Step from zero density to full scale, followed by a long wrap-heavy run.
    for (int c = 0; c < 10*R; c++) cycle(1'b1, 1'b0, 1'b0);
    nv         = 0;
    first_full = 99;
    for (int c = 0; c < 12000; c++) begin
      cycle(1'b1, 1'b1, 1'b0);
      if (pcm_valid) begin
        nv++;
        if (left_pcm == 12'hFFF && first_full == 99) first_full = nv;
      end
    end
    chk("step_settle_le2", int'(first_full <= 2), 1);
    chk("step_valid_count", nv, 12000 / R);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
